// File: rtl/adc_pkg.sv
// Shared types for the ADC sample averaging path.
// Provides sample width, sample type and the averager FSM state encoding.
package adc_pkg;

    localparam int ADC_DATA_WIDTH = 12;

    typedef logic [ADC_DATA_WIDTH-1:0] sample_t;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } avg_state_t;

endpackage

// File: rtl/sample_ring_buffer.sv
// N-deep circular sample buffer with a wrapping write pointer.
// Ports: clk_i, rst_ni (async), clr_i (ptr to 0), wr_en_i, wr_data_i,
//        rd_data_o (combinational: entry about to be overwritten).
module sample_ring_buffer import adc_pkg::*; #(
    parameter int DW = ADC_DATA_WIDTH,
    parameter int AW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    output logic [DW-1:0] rd_data_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;

    // Oldest entry sits at the write pointer once the window is full.
    assign rd_data_o = mem_q[wr_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
        end else if (wr_en_i) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
        end
    end

    // Storage is not reset; contents are only read after being written.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && !clr_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/adc_sample_averager.sv
// Moving average over the last 2^LOG2_N ADC samples, truncated.
// Ports: clock, async reset, sample strobe/data, clear; average + strobe,
//        window_full flag and saturating sample count.
module adc_sample_averager import adc_pkg::*; #(
    parameter int DATA_WIDTH = ADC_DATA_WIDTH,
    parameter int LOG2_N     = 8
) (
    input  logic                  MAX10_CLK1_50,
    input  logic                  reset_n,
    input  logic                  response_valid_in,
    input  logic [DATA_WIDTH-1:0] ADC_in,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] avg_out,
    output logic                  avg_valid,
    output logic                  window_full,
    output logic [LOG2_N:0]       sample_count
);

    localparam int SUM_W = DATA_WIDTH + LOG2_N;
    localparam logic [LOG2_N:0] N_CNT = {1'b1, {LOG2_N{1'b0}}};

    avg_state_t            state_q;
    logic [SUM_W-1:0]      sum_q, sum_d;
    logic [LOG2_N:0]       count_q, count_d;
    logic [DATA_WIDTH-1:0] avg_q;
    logic                  avg_valid_q;
    logic                  full_q;
    logic [DATA_WIDTH-1:0] oldest;
    logic                  accept;

    // clear wins over a simultaneous sample
    assign accept = response_valid_in && !clear;

    sample_ring_buffer #(
        .DW (DATA_WIDTH),
        .AW (LOG2_N)
    ) u_ring (
        .clk_i     (MAX10_CLK1_50),
        .rst_ni    (reset_n),
        .clr_i     (clear),
        .wr_en_i   (accept),
        .wr_data_i (ADC_in),
        .rd_data_o (oldest)
    );

    // Sum never exceeds N*(2^DW-1) and never drops below zero, since the
    // evicted sample is always part of the current sum.
    always_comb begin
        sum_d   = sum_q + SUM_W'(ADC_in);
        count_d = count_q + (LOG2_N + 1)'(1);
        if (state_q == RUN) begin
            sum_d = sum_d - SUM_W'(oldest);
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FILL;
            sum_q       <= '0;
            count_q     <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            avg_valid_q <= 1'b0;
            if (clear) begin
                state_q <= FILL;
                sum_q   <= '0;
                count_q <= '0;
                avg_q   <= '0;
                full_q  <= 1'b0;
            end else if (accept) begin
                sum_q <= sum_d;
                unique case (state_q)
                    FILL: begin
                        count_q <= count_d;
                        if (count_d == N_CNT) begin
                            state_q     <= RUN;
                            full_q      <= 1'b1;
                            avg_q       <= sum_d[SUM_W-1:LOG2_N];
                            avg_valid_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        avg_q       <= sum_d[SUM_W-1:LOG2_N];
                        avg_valid_q <= 1'b1;
                    end
                    default: begin
                        state_q <= FILL;
                    end
                endcase
            end
        end
    end

    assign avg_out      = avg_q;
    assign avg_valid    = avg_valid_q;
    assign window_full  = full_q;
    assign sample_count = count_q;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Self-checking bench for adc_sample_averager with a 4-deep window.
// Table vectors, corner sequences and random traffic against a queue model.
module tb_adc_sample_averager;

    localparam int DW = 12;
    localparam int L2 = 2;
    localparam int N  = 1 << L2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vld = 1'b0;
    logic          clr = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] avg_out;
    logic          avg_valid;
    logic          window_full;
    logic [L2:0]   sample_count;

    adc_sample_averager #(
        .DATA_WIDTH (DW),
        .LOG2_N     (L2)
    ) dut (
        .MAX10_CLK1_50     (clk),
        .reset_n           (rst_n),
        .response_valid_in (vld),
        .ADC_in            (din),
        .clear             (clr),
        .avg_out           (avg_out),
        .avg_valid         (avg_valid),
        .window_full       (window_full),
        .sample_count      (sample_count)
    );

    always #10 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // reference model: the window itself as a queue
    int q[$];
    int m_avg;
    int m_full;
    int m_valid;

    typedef struct {
        int v;
        int d;
        int c;
        int e_avg;
        int e_val;
        int e_full;
        int e_cnt;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_avg   = 0;
        m_full  = 0;
        m_valid = 0;
    endtask

    task automatic model_step(int v, int d, int c);
        int s;
        m_valid = 0;
        if (c != 0) begin
            q.delete();
            m_avg  = 0;
            m_full = 0;
        end else if (v != 0) begin
            if (q.size() == N) void'(q.pop_front());
            q.push_back(d);
            if (q.size() == N) begin
                s = 0;
                foreach (q[i]) s += q[i];
                m_avg   = s / N;
                m_valid = 1;
                m_full  = 1;
            end
        end
    endtask

    task automatic check_model(string tag);
        chk({tag, ".avg"}, int'(avg_out), m_avg);
        chk({tag, ".valid"}, int'(avg_valid), m_valid);
        chk({tag, ".full"}, int'(window_full), m_full);
        chk({tag, ".count"}, int'(sample_count), q.size());
    endtask

    // called at a negedge; returns at the following negedge
    task automatic drive(int v, int d, int c);
        vld = v[0];
        din = d[DW-1:0];
        clr = c[0];
        @(posedge clk);
        model_step(v, d, c);
        @(negedge clk);
        vld = 1'b0;
        clr = 1'b0;
    endtask

    task automatic set_vec(int i, int v, int d, int a, int e, int f, int n);
        tbl[i].v      = v;
        tbl[i].d      = d;
        tbl[i].c      = 0;
        tbl[i].e_avg  = a;
        tbl[i].e_val  = e;
        tbl[i].e_full = f;
        tbl[i].e_cnt  = n;
    endtask

    initial begin
        set_vec(0, 1, 1000, 0,    0, 0, 1);
        set_vec(1, 1, 1000, 0,    0, 0, 2);
        set_vec(2, 1, 1000, 0,    0, 0, 3);
        set_vec(3, 1, 1000, 1000, 1, 1, 4);
        set_vec(4, 0, 4095, 1000, 0, 1, 4);
        set_vec(5, 1, 2000, 1250, 1, 1, 4);
        set_vec(6, 1, 2000, 1500, 1, 1, 4);
        set_vec(7, 1, 2000, 1750, 1, 1, 4);
        set_vec(8, 1, 2000, 2000, 1, 1, 4);
        set_vec(9, 1, 3,    1500, 1, 1, 4);

        // reset held with active strobes of full-scale data
        model_reset();
        vld = 1'b1;
        din = 12'hFFF;
        repeat (5) begin
            @(negedge clk);
            chk("rst.avg", int'(avg_out), 0);
            chk("rst.valid", int'(avg_valid), 0);
            chk("rst.full", int'(window_full), 0);
            chk("rst.count", int'(sample_count), 0);
        end
        vld   = 1'b0;
        rst_n = 1'b1;

        // fill and slide
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].c);
            chk($sformatf("tbl%0d.avg", i), int'(avg_out), tbl[i].e_avg);
            chk($sformatf("tbl%0d.valid", i), int'(avg_valid), tbl[i].e_val);
            chk($sformatf("tbl%0d.full", i), int'(window_full), tbl[i].e_full);
            chk($sformatf("tbl%0d.count", i), int'(sample_count), tbl[i].e_cnt);
        end

        // full-scale back-to-back, then zeros
        for (int i = 0; i < 2 * N; i++) begin
            drive(1, 4095, 0);
            check_model("max");
        end
        chk("max.final", int'(avg_out), 4095);
        for (int i = 0; i < N; i++) begin
            drive(1, 0, 0);
            check_model("zero");
        end
        chk("zero.final", int'(avg_out), 0);

        // clear beats a simultaneous sample
        drive(1, 3000, 0);
        drive(1, 777, 1);
        check_model("clr");
        chk("clr.count", int'(sample_count), 0);
        chk("clr.avg", int'(avg_out), 0);
        for (int i = 0; i < N; i++) begin
            drive(1, 500, 0);
            check_model("refill");
        end
        chk("refill.valid", int'(avg_valid), 1);
        chk("refill.avg", int'(avg_out), 500);

        // async reset between edges while running
        drive(1, 2500, 0);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.avg", int'(avg_out), 0);
        chk("arst.valid", int'(avg_valid), 0);
        chk("arst.full", int'(window_full), 0);
        chk("arst.count", int'(sample_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            drive(1, 1000, 0);
            check_model("post");
        end
        chk("post.avg", int'(avg_out), 1000);
        chk("post.valid", int'(avg_valid), 1);

        // random traffic, mixed density, occasional clear
        for (int i = 0; i < 400; i++) begin
            drive(int'($urandom_range(0, 2) != 0),
                  int'($urandom_range(0, 4095)),
                  int'($urandom_range(0, 39) == 0));
            check_model("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
